// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for the immediate decode stage: upstream instruction side and downstream decoded side.
// The stage uses the slave modport; whatever drives instructions in and takes results out uses master.
interface imm_decode_stage_if #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic            out_illegal;
   logic [31:0]     out_inst;
   logic [PC_W-1:0] out_pc;

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
   );

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
   );
endinterface

// File: rtl/imm_decode_stage.sv
// RV32/RV64 immediate and format decode stage with a two-slot skid buffer so in_ready is a flop.
// state   | meaning
// EMPTY   | no entry held, out_valid low
// ONE     | main slot holds the entry driving out_*
// FULL    | main and skid both occupied, in_ready low
module imm_decode_stage #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input logic            clk,
   input logic            rst,
   imm_decode_stage_if.slave bus
);
   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("imm_decode_stage: XLEN must be 32 or 64");
      end
   endgenerate

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_SH   = 3'd6;
   localparam logic [2:0] FMT_Z    = 3'd7;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_FENCE    = 7'b0001111;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            ill;
      logic [31:0]     inst;
      logic [PC_W-1:0] pc;
   } entry_t;

   state_t          state;
   state_t          state_nxt;
   logic            in_ready_q;
   logic            accept;
   logic            drain;
   logic            load_main_in;
   logic            load_skid_in;
   logic            load_main_skid;
   entry_t          main_q;
   entry_t          skid_q;
   entry_t          dec;
   logic [XLEN-1:0] sx;
   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic            is_shift;

   assign opcode   = bus.in_inst[6:0];
   assign f3       = bus.in_inst[14:12];
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
   assign sx       = {XLEN{bus.in_inst[31]}};

   // Sign-extended formats start from all-sign-bits and overwrite the low field.
   always_comb begin
      dec.imm  = '0;
      dec.fmt  = FMT_NONE;
      dec.ill  = 1'b0;
      dec.inst = bus.in_inst;
      dec.pc   = bus.in_pc;
      case (opcode)
         OPC_LOAD, OPC_JALR: begin
            dec.fmt       = FMT_I;
            dec.imm       = sx;
            dec.imm[11:0] = bus.in_inst[31:20];
         end
         OPC_OPIMM: begin
            if (is_shift) begin
               if (XLEN == 32 && bus.in_inst[25]) begin
                  dec.ill = 1'b1;
               end else begin
                  dec.fmt      = FMT_SH;
                  dec.imm[5:0] = bus.in_inst[25:20];
               end
            end else begin
               dec.fmt       = FMT_I;
               dec.imm       = sx;
               dec.imm[11:0] = bus.in_inst[31:20];
            end
         end
         OPC_OPIMM32: begin
            if (XLEN == 32) begin
               dec.ill = 1'b1;
            end else if (is_shift) begin
               dec.fmt      = FMT_SH;
               dec.imm[4:0] = bus.in_inst[24:20];
            end else begin
               dec.fmt       = FMT_I;
               dec.imm       = sx;
               dec.imm[11:0] = bus.in_inst[31:20];
            end
         end
         OPC_STORE: begin
            dec.fmt       = FMT_S;
            dec.imm       = sx;
            dec.imm[11:0] = {bus.in_inst[31:25], bus.in_inst[11:7]};
         end
         OPC_BRANCH: begin
            dec.fmt       = FMT_B;
            dec.imm       = sx;
            dec.imm[12:0] = {bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25],
                             bus.in_inst[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.fmt       = FMT_U;
            dec.imm       = sx;
            dec.imm[31:0] = {bus.in_inst[31:12], 12'h000};
         end
         OPC_JAL: begin
            dec.fmt       = FMT_J;
            dec.imm       = sx;
            dec.imm[20:0] = {bus.in_inst[31], bus.in_inst[19:12], bus.in_inst[20],
                             bus.in_inst[30:21], 1'b0};
         end
         OPC_SYSTEM: begin
            case (f3)
               3'd5, 3'd6, 3'd7: begin
                  dec.fmt      = FMT_Z;
                  dec.imm[4:0] = bus.in_inst[19:15];
               end
               3'd1, 3'd2, 3'd3: begin
                  dec.fmt       = FMT_I;
                  dec.imm[11:0] = bus.in_inst[31:20];
               end
               3'd0: dec.fmt = FMT_NONE;
               default: dec.ill = 1'b1;
            endcase
         end
         OPC_OP, OPC_FENCE: dec.fmt = FMT_NONE;
         OPC_OP32: dec.ill = (XLEN == 32);
         default: dec.ill = 1'b1;
      endcase
   end

   assign accept = bus.in_valid && in_ready_q;
   assign drain  = (state != S_EMPTY) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != S_FULL);
      end
   end

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_skid_in   = 1'b0;
      load_main_skid = 1'b0;
      case (state)
         S_EMPTY: begin
            if (accept) begin
               load_main_in = 1'b1;
               state_nxt    = S_ONE;
            end
         end
         S_ONE: begin
            case ({accept, drain})
               2'b10: begin
                  load_skid_in = 1'b1;
                  state_nxt    = S_FULL;
               end
               2'b01: state_nxt = S_EMPTY;
               2'b11: load_main_in = 1'b1;
               default: state_nxt = S_ONE;
            endcase
         end
         S_FULL: begin
            if (drain) begin
               load_main_skid = 1'b1;
               state_nxt      = S_ONE;
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= dec;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid_in) begin
            skid_q <= dec;
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = (state != S_EMPTY);
   assign bus.out_imm     = main_q.imm;
   assign bus.out_fmt     = main_q.fmt;
   assign bus.out_illegal = main_q.ill;
   assign bus.out_inst    = main_q.inst;
   assign bus.out_pc      = main_q.pc;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and checks both against
// a queue-based occupancy model and an arithmetic decode model.
module tb_imm_decode_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        out_ready;
   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] q[$];

   always #5 clk = ~clk;

   imm_decode_stage_if #(.XLEN(32), .PC_W(32)) if32 ();
   imm_decode_stage_if #(.XLEN(64), .PC_W(32)) if64 ();

   assign if32.in_valid  = in_valid;
   assign if32.in_inst   = in_inst;
   assign if32.in_pc     = in_pc;
   assign if32.out_ready = out_ready;
   assign if64.in_valid  = in_valid;
   assign if64.in_inst   = in_inst;
   assign if64.in_pc     = in_pc;
   assign if64.out_ready = out_ready;

   imm_decode_stage #(.XLEN(32), .PC_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
   imm_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference decode written from the instruction-set rules using signed arithmetic.
   function automatic void model(input logic [31:0] i, input int xl,
                                 output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
      longint v   = 0;
      bit     r64 = (xl == 64);
      bit     sh  = (i[14:12] == 3'd1) || (i[14:12] == 3'd5);
      fmt = 3'd0;
      ill = 1'b0;
      case (i[6:0])
         7'h03, 7'h67: begin fmt = 3'd1; v = longint'($signed(i[31:20])); end
         7'h13: begin
            if (sh) begin
               if (!r64 && i[25]) ill = 1'b1;
               else begin fmt = 3'd6; v = r64 ? longint'(i[25:20]) : longint'(i[24:20]); end
            end else begin
               fmt = 3'd1; v = longint'($signed(i[31:20]));
            end
         end
         7'h1B: begin
            if (!r64) ill = 1'b1;
            else if (sh) begin fmt = 3'd6; v = longint'(i[24:20]); end
            else begin fmt = 3'd1; v = longint'($signed(i[31:20])); end
         end
         7'h23: begin fmt = 3'd2; v = longint'($signed({i[31:25], i[11:7]})); end
         7'h63: begin fmt = 3'd3; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
         7'h37, 7'h17: begin fmt = 3'd4; v = longint'($signed({i[31:12], 12'h000})); end
         7'h6F: begin fmt = 3'd5; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
         7'h73: begin
            case (i[14:12])
               3'd5, 3'd6, 3'd7: begin fmt = 3'd7; v = longint'(i[19:15]); end
               3'd1, 3'd2, 3'd3: begin fmt = 3'd1; v = longint'(i[31:20]); end
               3'd0: v = 0;
               default: ill = 1'b1;
            endcase
         end
         7'h33, 7'h0F: v = 0;
         7'h3B: ill = !r64;
         default: ill = 1'b1;
      endcase
      if (ill) begin fmt = 3'd0; v = 0; end
      imm = r64 ? 64'(v) : {32'h0, v[31:0]};
   endfunction

   // One cycle: sample outputs 1ns after the negedge, update the occupancy model, advance.
   task automatic step();
      logic [63:0] h;
      logic [63:0] e;
      logic [2:0]  f;
      logic        l;
      int          n;
      #1;
      n = q.size();
      if (rst) begin
         q.delete();
      end else begin
         chk("out_valid32", if32.out_valid, n != 0);
         chk("out_valid64", if64.out_valid, n != 0);
         chk("in_ready32", if32.in_ready, n < 2);
         chk("in_ready64", if64.in_ready, n < 2);
         if (out_ready && n != 0) begin
            h = q.pop_front();
            model(h[63:32], 32, e, f, l);
            chk("inst32", if32.out_inst, h[63:32]);
            chk("pc32", if32.out_pc, h[31:0]);
            chk("imm32", if32.out_imm, e);
            chk("fmt32", if32.out_fmt, f);
            chk("illegal32", if32.out_illegal, l);
            model(h[63:32], 64, e, f, l);
            chk("inst64", if64.out_inst, h[63:32]);
            chk("pc64", if64.out_pc, h[31:0]);
            chk("imm64", if64.out_imm, e);
            chk("fmt64", if64.out_fmt, f);
            chk("illegal64", if64.out_illegal, l);
         end
         if (in_valid && n < 2) q.push_back({in_inst, in_pc});
      end
      @(negedge clk);
   endtask

   task automatic direct(input logic [31:0] i,
                         input logic [63:0] e32, input logic [2:0] f32, input logic l32,
                         input logic [63:0] e64, input logic [2:0] f64, input logic l64);
      in_valid  = 1'b1;
      in_inst   = i;
      in_pc     = 32'h0000_1000;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      chk("dir_valid32", if32.out_valid, 1'b1);
      chk("dir_imm32", if32.out_imm, e32);
      chk("dir_fmt32", if32.out_fmt, f32);
      chk("dir_ill32", if32.out_illegal, l32);
      chk("dir_valid64", if64.out_valid, 1'b1);
      chk("dir_imm64", if64.out_imm, e64);
      chk("dir_fmt64", if64.out_fmt, f64);
      chk("dir_ill64", if64.out_illegal, l64);
      step();
   endtask

   logic [6:0] ops [14] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h3B, 7'h7F};

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_inst   = 32'h0;
      in_pc     = 32'h0;
      out_ready = 1'b0;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_valid32", if32.out_valid, 1'b0);
      chk("rst_ready32", if32.in_ready, 1'b1);
      chk("rst_imm32", if32.out_imm, 64'h0);
      chk("rst_fmt32", if32.out_fmt, 3'd0);
      chk("rst_ill32", if32.out_illegal, 1'b0);
      chk("rst_inst32", if32.out_inst, 32'h0);
      chk("rst_pc32", if32.out_pc, 32'h0);
      chk("rst_valid64", if64.out_valid, 1'b0);
      chk("rst_ready64", if64.in_ready, 1'b1);
      chk("rst_imm64", if64.out_imm, 64'h0);
      step();

      direct(32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
      direct(32'hFE000EE3, 64'hFFFF_FFFC, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
      direct(32'h123450B7, 64'h1234_5000, 3'd4, 1'b0, 64'h1234_5000, 3'd4, 1'b0);
      direct(32'h01F09093, 64'd31, 3'd6, 1'b0, 64'd31, 3'd6, 1'b0);
      direct(32'h02009093, 64'd0, 3'd0, 1'b1, 64'd32, 3'd6, 1'b0);
      direct(32'h800000B7, 64'h8000_0000, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
      direct(32'h0050E073, 64'd1, 3'd7, 1'b0, 64'd1, 3'd7, 1'b0);
      direct(32'h0000007F, 64'd0, 3'd0, 1'b1, 64'd0, 3'd0, 1'b1);
      direct(32'h00000000, 64'd0, 3'd0, 1'b1, 64'd0, 3'd0, 1'b1);
      direct(32'h0020A423, 64'd8, 3'd2, 1'b0, 64'd8, 3'd2, 1'b0);
      direct(32'hFFDFF0EF, 64'hFFFF_FFFC, 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0);
      direct(32'h0020809B, 64'd0, 3'd0, 1'b1, 64'd2, 3'd1, 1'b0);
      direct(32'h0000003B, 64'd0, 3'd0, 1'b1, 64'd0, 3'd0, 1'b0);

      // Backpressure: A and B fill both slots, C waits until the stall releases.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00100093; in_pc = 32'hA;
      step();
      in_inst   = 32'h00200093; in_pc = 32'hB;
      step();
      in_inst   = 32'h00300093; in_pc = 32'hC;
      #1;
      chk("bp_ready32", if32.in_ready, 1'b0);
      chk("bp_ready64", if64.in_ready, 1'b0);
      chk("bp_head32", if32.out_inst, 32'h00100093);
      step();
      step();
      out_ready = 1'b1;
      step();
      step();
      in_valid = 1'b0;
      step();
      step();

      // Reset while FULL discards both entries.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00500093; in_pc = 32'h50;
      step();
      in_inst   = 32'h00600093; in_pc = 32'h60;
      step();
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rstfull_valid32", if32.out_valid, 1'b0);
      chk("rstfull_ready32", if32.in_ready, 1'b1);
      chk("rstfull_valid64", if64.out_valid, 1'b0);
      chk("rstfull_ready64", if64.in_ready, 1'b1);
      step();

      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_inst   = $urandom;
         if ($urandom_range(0, 7) != 0) in_inst[6:0] = ops[$urandom_range(0, 13)];
         in_pc     = $urandom;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
